ps2_key_ctrl: RTL

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

---
 rtl/ps2_pkg.sv | 13 +
 rtl/ps2_byte_fetch.sv | 52 +++++
 rtl/ps2_key_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 scan-code constants and fetch state encoding
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      RELEASE = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/ps2_byte_fetch.sv
// rtl/ps2_byte_fetch.sv - pops one byte from the PS/2 receiver FIFO every three cycles
module ps2_byte_fetch
   import ps2_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_ready,
   input  logic [7:0] rx_data,
   output logic       rx_nextdata_n,
   output logic [7:0] byte_q,
   output logic       byte_vld
);

   fetch_state_e state_q, state_d;
   logic [7:0]   byte_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         byte_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
      end
   end

   // Pop strobe and valid decode straight from state so reset releases them at once
   always_comb begin
      state_d       = state_q;
      byte_d        = byte_q;
      rx_nextdata_n = 1'b1;
      byte_vld      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rx_ready) begin
               byte_d  = rx_data;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            rx_nextdata_n = 1'b0;
            state_d       = RELEASE;
         end
         RELEASE: begin
            byte_vld = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - decodes PS/2 set-2 make/break/repeat sequences into key events
module ps2_key_ctrl
   import ps2_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             rx_ready,
   input  logic [7:0]       rx_data,
   input  logic             rx_overflow,
   output logic             rx_nextdata_n,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_pressed,
   output logic             key_make,
   output logic             key_repeat,
   output logic             key_break,
   output logic [CNT_W-1:0] key_count,
   output logic             ovf_sticky
);

   logic [7:0]       fetch_byte;
   logic             fetch_vld;
   logic [7:0]       code_q, code_d;
   logic             key_ext_q, key_ext_d;
   logic             pressed_q, pressed_d;
   logic             make_q, make_d, repeat_q, repeat_d, break_q, break_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             ext_q, ext_d, brk_q, brk_d;
   logic             same_key;

   ps2_byte_fetch u_fetch (
      .clock         (clock),
      .reset         (reset),
      .rx_ready      (rx_ready),
      .rx_data       (rx_data),
      .rx_nextdata_n (rx_nextdata_n),
      .byte_q        (fetch_byte),
      .byte_vld      (fetch_vld)
   );

   assign same_key = (fetch_byte == code_q) && (ext_q == key_ext_q);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         code_q    <= 8'h00;
         key_ext_q <= 1'b0;
         pressed_q <= 1'b0;
         make_q    <= 1'b0;
         repeat_q  <= 1'b0;
         break_q   <= 1'b0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         ext_q     <= 1'b0;
         brk_q     <= 1'b0;
      end else begin
         code_q    <= code_d;
         key_ext_q <= key_ext_d;
         pressed_q <= pressed_d;
         make_q    <= make_d;
         repeat_q  <= repeat_d;
         break_q   <= break_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         ext_q     <= ext_d;
         brk_q     <= brk_d;
      end
   end

   always_comb begin
      code_d    = code_q;
      key_ext_d = key_ext_q;
      pressed_d = pressed_q;
      make_d    = 1'b0;
      repeat_d  = 1'b0;
      break_d   = 1'b0;
      count_d   = count_q;
      ovf_d     = ovf_q;
      ext_d     = ext_q;
      brk_d     = brk_q;
      if (fetch_vld) begin
         if (fetch_byte == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (fetch_byte == PS2_BRK) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (brk_q) begin
               break_d = 1'b1;
               count_d = count_q + CNT_W'(1);
               if (same_key) pressed_d = 1'b0;
            end else if (pressed_q && same_key) begin
               repeat_d = 1'b1;
            end else begin
               code_d    = fetch_byte;
               key_ext_d = ext_q;
               pressed_d = 1'b1;
               make_d    = 1'b1;
            end
         end
      end
      // Overflow means prefixes may have been lost, so pending flags are untrustworthy
      if (rx_overflow) begin
         ovf_d = 1'b1;
         ext_d = 1'b0;
         brk_d = 1'b0;
      end
   end

   assign key_code    = code_q;
   assign key_ext     = key_ext_q;
   assign key_pressed = pressed_q;
   assign key_make    = make_q;
   assign key_repeat  = repeat_q;
   assign key_break   = break_q;
   assign key_count   = count_q;
   assign ovf_sticky  = ovf_q;

endmodule
